// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path that drains the byte FIFO.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud
    localparam int FIFO_WIDTH           = 8;
    localparam int START_BITS           = 1;
    localparam int STOP_BITS            = 1;
    localparam int FRAME_BITS           = START_BITS + FIFO_WIDTH + STOP_BITS;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_POP   = 3'd1;
    localparam logic [2:0] ENC_LOAD  = 3'd2;
    localparam logic [2:0] ENC_START = 3'd3;
    localparam logic [2:0] ENC_DATA  = 3'd4;
    localparam logic [2:0] ENC_STOP  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_POP   = ENC_POP,
        ST_LOAD  = ENC_LOAD,
        ST_START = ENC_START,
        ST_DATA  = ENC_DATA,
        ST_STOP  = ENC_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps, and flags the terminal count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge sysclk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that owns the FIFO read port: one pop per frame, frames back-to-back
// while data is available and transmission is enabled.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = FIFO_WIDTH
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rdata,
    output logic                 fifo_read_en,
    output logic                 tx,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shift;
    logic [IDX_W-1:0]       bit_idx;
    logic                   tick;
    logic                   timer_clear;
    logic                   can_start;

    assign can_start = tx_enable && !fifo_empty;

    // Holding the timer at zero outside the frame lines START up exactly with LOAD's closing edge.
    assign timer_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (tick)
    );

    // Pure state decodes: the pop strobe can never coincide with anything but POP.
    assign fifo_read_en = (state == ST_POP);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_start) state <= ST_POP;
                end
                ST_POP: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift <= fifo_rdata;
                    tx    <= 1'b0;
                    state <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Empty flag and enable are re-sampled only here, allowing back-to-back frames.
                    if (tick) state <= can_start ? ST_POP : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
